// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_pkg
// Purpose  : Shared types and frame geometry for the serial ADC capture path.
// Revision : 1.0 - initial release
// ============================================================================
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } adc_state_t;

    localparam int FRAME_BITS   = 16;
    localparam int LEAD_ZEROS   = 3;
    localparam int DATA_BITS    = 8;
    localparam int DATA_MSB_IDX = 3;
    localparam int DATA_LSB_IDX = 10;

    function automatic logic is_data_bit(input logic [3:0] idx);
        return (idx >= 4'(DATA_MSB_IDX)) && (idx <= 4'(DATA_LSB_IDX));
    endfunction

    function automatic logic is_lead_bit(input logic [3:0] idx);
        return idx < 4'(LEAD_ZEROS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sclk_div.sv
`default_nettype none
// ============================================================================
// Module   : adc_sclk_div
// Purpose  : Half-period counter producing the SCLK phase and a toggle strobe.
// Revision : 1.0 - initial release
// ============================================================================
module adc_sclk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_tick,
    output logic o_sclk
);

    logic [7:0] r_cnt;
    logic       r_phase;

    // Strobe depends on the counter only, so the caller may derive i_run from it.
    assign o_tick = (r_cnt == 8'(CLK_DIV - 1));
    assign o_sclk = r_phase;

    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_cnt   <= 8'd0;
            r_phase <= 1'b1;
        end else if (o_tick) begin
            r_cnt   <= 8'd0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_spi_reader.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_reader
// Purpose  : Drives an 8-bit SPI ADC frame and presents samples on valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 8
) (
    input  logic       core_clk,
    input  logic       core_reset,
    input  logic       enable,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    input  logic       adc_miso,
    output logic [7:0] sample_data,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       overrun,
    output logic       frame_err
);

    adc_state_t           r_state;
    adc_state_t           w_next_state;
    logic [3:0]           r_bit_cnt;
    logic [7:0]           r_gap_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_overrun;
    logic                 r_frame_err;
    logic                 r_cs_n;

    logic w_tick;
    logic w_sclk;
    logic w_active;
    logic w_active_next;
    logic w_run;
    logic w_rise;
    logic w_bit_end;
    logic w_deliver;
    logic w_accept;

    assign w_active      = (r_state == SETUP) || (r_state == SHIFT);
    assign w_active_next = (w_next_state == SETUP) || (w_next_state == SHIFT);
    // Divider restarts on frame entry and parks high on frame exit.
    assign w_run         = w_active && w_active_next;
    assign w_rise        = (r_state == SHIFT) && w_tick && !w_sclk;
    assign w_bit_end     = (r_state == SHIFT) && w_tick && w_sclk;
    assign w_deliver     = (r_state == SHIFT) && (w_next_state == GAP);
    assign w_accept      = r_valid && sample_ready;

    adc_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk    (core_clk),
        .rst    (core_reset),
        .i_run  (w_run),
        .o_tick (w_tick),
        .o_sclk (w_sclk)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (enable) w_next_state = SETUP;
            SETUP:   if (w_tick) w_next_state = SHIFT;
            SHIFT:   if (w_bit_end && (r_bit_cnt == 4'(FRAME_BITS - 1))) w_next_state = GAP;
            GAP:     if (r_gap_cnt == 8'(QUIET_CYCLES - 1)) w_next_state = enable ? SETUP : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            r_state <= IDLE;
            r_cs_n  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_cs_n  <= !w_active_next;
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_reset || (r_state != SHIFT)) begin
            r_bit_cnt <= 4'd0;
        end else if (w_bit_end) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_reset || (r_state != GAP)) begin
            r_gap_cnt <= 8'd0;
        end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
        end
    end

    // MISO is sampled on the edge that raises SCLK.
    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            r_shift <= '0;
        end else if (w_rise && is_data_bit(r_bit_cnt)) begin
            r_shift <= {r_shift[DATA_BITS-2:0], adc_miso};
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_rise && is_lead_bit(r_bit_cnt) && adc_miso) begin
                r_frame_err <= 1'b1;
            end
            if (w_deliver && (!r_valid || w_accept)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_deliver) begin
                r_overrun <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign adc_cs_n     = r_cs_n;
    assign adc_sclk     = w_sclk;
    assign sample_data  = r_data;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;
    assign frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_spi_reader
// Purpose  : Self-checking bench with an ADC frame model and sample scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_reader;

    localparam int D         = 4;
    localparam int Q         = 8;
    localparam int PERIOD    = 33 * D + Q;
    localparam int VALID_LAT = 1 + 33 * D;

    logic       core_clk     = 1'b0;
    logic       core_reset   = 1'b1;
    logic       enable       = 1'b0;
    logic       adc_miso     = 1'b0;
    logic       sample_ready = 1'b0;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       overrun;
    logic       frame_err;

    int          cyc      = 0;
    int          n_checks = 0;
    int          n_err    = 0;
    logic [15:0] adc_q[$];
    logic [7:0]  exp_q[$];
    int          hs_cyc[$];
    logic [15:0] cur_word = 16'h0;
    int          bit_idx  = 0;

    typedef struct {
        logic [2:0] lead;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    adc_spi_reader #(
        .CLK_DIV      (D),
        .QUIET_CYCLES (Q)
    ) dut (
        .core_clk     (core_clk),
        .core_reset   (core_reset),
        .enable       (enable),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .adc_miso     (adc_miso),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    always #5 core_clk = ~core_clk;

    always @(posedge core_clk) cyc <= cyc + 1;

    always @(posedge core_clk) begin
        if (cyc > 20000) begin
            $display("FAIL watchdog: cycle %0d exceeds limit 20000", cyc);
            $fatal(1);
        end
    end

    // ADC model: frame word popped at CS fall, next bit shifted out on each SCLK fall.
    always @(negedge adc_cs_n) begin
        cur_word = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0;
        bit_idx  = 0;
    end

    always @(negedge adc_sclk) begin
        if (!adc_cs_n && bit_idx < 16) begin
            adc_miso = cur_word[15 - bit_idx];
            bit_idx  = bit_idx + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Handshake monitor: a sample is consumed at the edge following valid && ready.
    always @(negedge core_clk) begin
        if (!core_reset && sample_valid && sample_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("sb_unexpected", {24'h0, sample_data}, 32'hFFFF_FFFF);
            end else begin
                check("sb_data", {24'h0, sample_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [15:0] mk(input logic [2:0] lead, input logic [7:0] d);
        return {lead, d, 5'b10110};
    endfunction

    task automatic goto_drive(input int c);
        do begin
            @(posedge core_clk);
            #2;
        end while (cyc < c);
    endtask

    task automatic wait_to(input int c);
        do @(negedge core_clk); while (cyc < c);
    endtask

    task automatic apply_reset();
        @(posedge core_clk);
        #2;
        core_reset   = 1'b1;
        enable       = 1'b0;
        sample_ready = 1'b0;
        @(posedge core_clk);
        #2;
        @(posedge core_clk);
        #2;
        core_reset   = 1'b0;
    endtask

    initial begin
        int   t0;
        int   t1;
        int   lows;
        logic [7:0] b2b[3];

        vecs[0] = '{lead: 3'b000, data: 8'hA5, exp_data: 8'hA5, exp_ferr: 1'b0};
        vecs[1] = '{lead: 3'b000, data: 8'h00, exp_data: 8'h00, exp_ferr: 1'b0};
        vecs[2] = '{lead: 3'b000, data: 8'hFF, exp_data: 8'hFF, exp_ferr: 1'b0};
        vecs[3] = '{lead: 3'b010, data: 8'h7E, exp_data: 8'h7E, exp_ferr: 1'b1};
        vecs[4] = '{lead: 3'b100, data: 8'h3C, exp_data: 8'h3C, exp_ferr: 1'b1};
        vecs[5] = '{lead: 3'b001, data: 8'h81, exp_data: 8'h81, exp_ferr: 1'b1};

        // Reset values
        apply_reset();
        wait_to(cyc);
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 1);
        check("rst_data", sample_data, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);

        // Single frames from reset, one per table entry
        for (int i = 0; i < 6; i++) begin
            apply_reset();
            adc_q.push_back(mk(vecs[i].lead, vecs[i].data));
            exp_q.push_back(vecs[i].exp_data);
            enable = 1'b1;
            t0 = cyc;
            wait_to(t0);
            check($sformatf("v%0d_cs_idle", i), adc_cs_n, 1);
            wait_to(t0 + 1);
            check($sformatf("v%0d_cs_fall", i), adc_cs_n, 0);
            check($sformatf("v%0d_sclk_setup", i), adc_sclk, 1);
            goto_drive(t0 + 2);
            enable = 1'b0;
            wait_to(t0 + 1 + D);
            check($sformatf("v%0d_sclk_fall0", i), adc_sclk, 0);
            wait_to(t0 + 1 + 2 * D);
            check($sformatf("v%0d_sclk_rise0", i), adc_sclk, 1);
            wait_to(t0 + VALID_LAT - 1);
            check($sformatf("v%0d_valid_early", i), sample_valid, 0);
            check($sformatf("v%0d_cs_last", i), adc_cs_n, 0);
            wait_to(t0 + VALID_LAT);
            check($sformatf("v%0d_valid", i), sample_valid, 1);
            check($sformatf("v%0d_data", i), sample_data, vecs[i].exp_data);
            check($sformatf("v%0d_frame_err", i), frame_err, vecs[i].exp_ferr);
            check($sformatf("v%0d_overrun", i), overrun, 0);
            check($sformatf("v%0d_cs_rise", i), adc_cs_n, 1);
            goto_drive(t0 + VALID_LAT + 2);
            sample_ready = 1'b1;
            goto_drive(t0 + VALID_LAT + 3);
            sample_ready = 1'b0;
            wait_to(t0 + VALID_LAT + 3);
            check($sformatf("v%0d_valid_clr", i), sample_valid, 0);
            wait_to(t0 + VALID_LAT + 20);
            check($sformatf("v%0d_idle_cs", i), adc_cs_n, 1);
            check($sformatf("v%0d_idle_sclk", i), adc_sclk, 1);
        end

        // Back-to-back frames with ready held high
        apply_reset();
        hs_cyc.delete();
        sample_ready = 1'b1;
        b2b[0] = 8'h00;
        b2b[1] = 8'hFF;
        b2b[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            adc_q.push_back(mk(3'b000, b2b[i]));
            exp_q.push_back(b2b[i]);
        end
        enable = 1'b1;
        t0 = cyc;
        goto_drive(t0 + 300);
        enable = 1'b0;
        wait_to(t0 + VALID_LAT + 2 * PERIOD + 5);
        check("b2b_hs_count", hs_cyc.size(), 3);
        if (hs_cyc.size() >= 3) begin
            check("b2b_hs0", hs_cyc[0] - t0, VALID_LAT);
            check("b2b_gap01", hs_cyc[1] - hs_cyc[0], PERIOD);
            check("b2b_gap12", hs_cyc[2] - hs_cyc[1], PERIOD);
        end
        check("b2b_overrun", overrun, 0);
        wait_to(t0 + 3 * PERIOD + 10);
        check("b2b_no_fourth", adc_cs_n, 1);
        goto_drive(cyc + 1);
        sample_ready = 1'b0;

        // Overrun: two frames with ready low
        apply_reset();
        adc_q.push_back(mk(3'b000, 8'h11));
        adc_q.push_back(mk(3'b000, 8'h22));
        exp_q.push_back(8'h11);
        enable = 1'b1;
        t0 = cyc;
        goto_drive(t0 + 200);
        enable = 1'b0;
        wait_to(t0 + PERIOD + VALID_LAT - 1);
        check("ovr_before", overrun, 0);
        wait_to(t0 + PERIOD + VALID_LAT);
        check("ovr_set", overrun, 1);
        check("ovr_valid", sample_valid, 1);
        check("ovr_data_kept", sample_data, 8'h11);
        goto_drive(t0 + PERIOD + VALID_LAT + 7);
        sample_ready = 1'b1;
        goto_drive(t0 + PERIOD + VALID_LAT + 8);
        sample_ready = 1'b0;
        wait_to(t0 + PERIOD + VALID_LAT + 8);
        check("ovr_valid_clr", sample_valid, 0);
        check("ovr_sticky", overrun, 1);

        // Enable dropped during SHIFT bit 5
        apply_reset();
        adc_q.push_back(mk(3'b000, 8'h5A));
        exp_q.push_back(8'h5A);
        enable = 1'b1;
        t0 = cyc;
        goto_drive(t0 + 1 + 11 * D + 1);
        enable = 1'b0;
        wait_to(t0 + VALID_LAT);
        check("en_valid", sample_valid, 1);
        check("en_data", sample_data, 8'h5A);
        lows = 0;
        for (int c = t0 + VALID_LAT + Q; c <= t0 + 200; c++) begin
            wait_to(c);
            if (adc_cs_n == 1'b0) lows = lows + 1;
        end
        check("en_no_setup", lows, 0);
        check("en_idle_sclk", adc_sclk, 1);
        goto_drive(t0 + 201);
        sample_ready = 1'b1;
        goto_drive(t0 + 202);
        sample_ready = 1'b0;
        wait_to(t0 + 202);
        check("en_valid_clr", sample_valid, 0);

        // Reset pulsed during SHIFT bit 9, then a clean restart
        apply_reset();
        adc_q.push_back(mk(3'b111, 8'h99));
        enable = 1'b1;
        t0 = cyc;
        wait_to(t0 + 70);
        check("mid_ferr_pre", frame_err, 1);
        goto_drive(t0 + 1 + 19 * D + 1);
        adc_q.push_back(mk(3'b000, 8'hC3));
        exp_q.push_back(8'hC3);
        core_reset = 1'b1;
        goto_drive(t0 + 1 + 19 * D + 2);
        core_reset = 1'b0;
        wait_to(t0 + 1 + 19 * D + 2);
        check("mid_cs_n", adc_cs_n, 1);
        check("mid_sclk", adc_sclk, 1);
        check("mid_valid", sample_valid, 0);
        check("mid_overrun", overrun, 0);
        check("mid_frame_err", frame_err, 0);
        t1 = cyc;
        wait_to(t1 + 1);
        check("mid_restart_cs", adc_cs_n, 0);
        goto_drive(t1 + 2);
        enable = 1'b0;
        wait_to(t1 + VALID_LAT);
        check("mid_restart_valid", sample_valid, 1);
        check("mid_restart_data", sample_data, 8'hC3);
        check("mid_restart_ferr", frame_err, 0);
        goto_drive(t1 + VALID_LAT + 2);
        sample_ready = 1'b1;
        goto_drive(t1 + VALID_LAT + 3);
        sample_ready = 1'b0;
        wait_to(t1 + VALID_LAT + 3);

        check("sb_drained", exp_q.size(), 0);
        check("adc_q_drained", adc_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
